// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parameterised register file.
// Write-through bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } clrState_e;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;

endpackage

// File: rtl/regfile_if.sv
// Register file access bundle: write port, read ports and clear handshake.
// The master drives requests; the slave is the register file.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD
);
  localparam int AW = $clog2(NREGS);

  logic              RegWrite;
  logic [AW-1:0]     RD;
  logic [XLEN-1:0]   WriteData;
  logic [NRD*AW-1:0] RS;
  logic [NRD*XLEN-1:0] ReadData;
  logic              clr_req;
  logic              busy;
  logic              clr_done;

  modport master (
    output RegWrite, RD, WriteData, RS, clr_req,
    input  ReadData, busy, clr_done
  );

  modport slave (
    input  RegWrite, RD, WriteData, RS, clr_req,
    output ReadData, busy, clr_done
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks a pointer from 1 to NREGS-1, one register per cycle.
// busy and clrDone are registered; reset aborts a clear without clrDone.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clrReq,
  output logic          busy,
  output logic          clrDone,
  output logic          clrEn,
  output logic [AW-1:0] clrPtr
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  clrState_e state;
  logic [AW-1:0] ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= AW'(1);
      busy    <= 1'b0;
      clrDone <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          clrDone <= 1'b0;
          if (clrReq) begin
            state   <= CLEAR;
            ptr     <= AW'(1);
            busy    <= 1'b1;
            clrDone <= (NREGS == 2);
          end
        end
        CLEAR: begin
          // clrReq is deliberately not looked at here: no restart
          if (ptr == LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clrDone <= 1'b0;
          end else begin
            ptr     <= ptr + AW'(1);
            clrDone <= (ptr == LAST - AW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clrEn  = (state == CLEAR);
  assign clrPtr = ptr;

endmodule

// File: rtl/regfile_param.sv
// Parameterised multi-port register file with x0 hard-wired to zero.
// Optional write-through on read ports via REGFILE_BYPASS_EN.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD
) (
  input logic     clk,
  input logic     reset,
  regfile_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic            busy;
  logic            clrDone;
  logic            clrEn;
  logic [AW-1:0]   clrPtr;
  logic            we;

  regfile_clear_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr (
    .clk     (clk),
    .reset   (reset),
    .clrReq  (bus.clr_req),
    .busy    (busy),
    .clrDone (clrDone),
    .clrEn   (clrEn),
    .clrPtr  (clrPtr)
  );

  assign we = bus.RegWrite && !busy && (bus.RD != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clrEn) begin
      regs[clrPtr] <= '0;
    end else if (we) begin
      regs[bus.RD] <= bus.WriteData;
    end
  end

  logic [NRD*XLEN-1:0] rdAll;
  logic [AW-1:0]       rsK;

  always_comb begin
    rdAll = '0;
    rsK   = '0;
    for (int k = 0; k < NRD; k++) begin
      rsK = bus.RS[k*AW +: AW];
      if (rsK != '0) begin
        rdAll[k*XLEN +: XLEN] = regs[rsK];
      end
`ifdef REGFILE_BYPASS_EN
      if (we && (rsK == bus.RD)) begin
        rdAll[k*XLEN +: XLEN] = bus.WriteData;
      end
`endif
    end
  end

  assign bus.ReadData = rdAll;
  assign bus.busy     = busy;
  assign bus.clr_done = clrDone;

endmodule
